tag_match_pipe: RTL
===================

TAG_MATCH_PIPE -- requirements
Module: tag_match_pipe

Interface
REQ-001 SHALL have parameter TAG_W, 20, width of each tag in bits (1..32).
REQ-002 SHALL have parameter WAYS, 4, number of ways compared in parallel (2..16).
REQ-003 SHALL have parameter CNT_W, 16, width of the hit and miss statistics counters.
REQ-004 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_req_valid  input  1  a request is present.
REQ-007 SHALL have port o_req_ready  output  1  the block accepts a request this cycle.
REQ-008 SHALL have port i_tag  input  TAG_W  lookup tag.
REQ-009 SHALL have port i_way_tag  input  WAYS*TAG_W  stored tags; way k occupies bits [k*TAG_W +: TAG_W].
REQ-010 SHALL have port i_way_vld  input  WAYS  per-way valid bits.
REQ-011 SHALL have port o_rsp_valid  output  1  a result is held.
REQ-012 SHALL have port i_rsp_ready  input  1  the consumer takes the result.
REQ-013 SHALL have port o_hit  output  1  at least one valid way matched.
REQ-014 SHALL have port o_hit_oh  output  WAYS  one-hot-or-more vector of matching valid ways.
REQ-015 SHALL have port o_hit_idx  output  IDX_W  index of the lowest-numbered matching way; IDX_W = max(1, clog2(WAYS)).
REQ-016 SHALL have port o_multi_hit  output  1  more than one valid way matched (error flag).
REQ-017 SHALL have port i_cnt_clr  input  1  synchronous clear of both counters.
REQ-018 SHALL have ports o_hit_cnt and o_miss_cnt  output  CNT_W  saturating statistics counters.

Function
REQ-019 Way k SHALL match when i_way_vld[k]=1 and all TAG_W bits of way k equal i_tag.
REQ-020 A request SHALL be accepted in a cycle when i_req_valid=1 and o_req_ready=1.
REQ-021 o_req_ready SHALL equal (~o_rsp_valid | i_rsp_ready), combinationally.
REQ-022 On accept, the match result SHALL be registered, and o_rsp_valid SHALL be 1 in the next cycle (latency 1).
REQ-023 While o_rsp_valid=1 and i_rsp_ready=0, all response outputs SHALL hold stable.
REQ-024 Simultaneous response consume and new accept SHALL load the new result with o_rsp_valid staying 1 (full throughput, no bubble).
REQ-025 Consume without accept SHALL clear o_rsp_valid next cycle.
REQ-026 o_hit_idx SHALL be 0 when o_hit=0; o_multi_hit SHALL be 0 when fewer than two ways matched.
REQ-027 On each accept, o_hit_cnt SHALL increment if the result hits, and o_miss_cnt SHALL increment otherwise; both counters SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-028 i_cnt_clr=1 SHALL zero both counters next cycle and SHALL take precedence over a same-cycle increment.
REQ-029 Response outputs SHALL be undriven by state only through registers; no combinational path from i_tag to o_hit.

Reset
REQ-030 While i_rst_n=0, o_rsp_valid, o_hit, o_hit_oh, o_hit_idx, o_multi_hit, o_hit_cnt and o_miss_cnt SHALL be 0, asynchronously.
REQ-031 Reset asserted with a pending response SHALL discard that response; after release, o_req_ready SHALL be 1.

Structure
REQ-032 A shared package tag_match_pkg SHALL hold default TAG_W/WAYS/CNT_W constants and the IDX_W derivation function.
REQ-033 Per-way equality SHALL be a sub-module tag_eq (parametrised width, XOR/NOR-reduce), instantiated WAYS times via generate.

Verification
REQ-034 Tags [0x12345,0xABCDE,0x00000,0xFFFFF], vld=4'b1111, i_tag=0xABCDE -> next cycle o_hit=1, o_hit_oh=4'b0010, o_hit_idx=1, o_multi_hit=0, o_hit_cnt=1.
REQ-035 Same tags, vld=4'b1101, i_tag=0xABCDE -> o_hit=0, o_hit_oh=0, o_hit_idx=0, o_miss_cnt=1.
REQ-036 Ways 1 and 3 both 0x0F0F0, vld=4'b1111, i_tag=0x0F0F0 -> o_hit_oh=4'b1010, o_hit_idx=1, o_multi_hit=1.
REQ-037 i_rsp_ready=0 for 3 cycles after response -> outputs stable, o_req_ready=0; back-to-back requests with i_rsp_ready=1 -> one response per cycle.
REQ-038 CNT_W=2, 5 hits -> o_hit_cnt stays 3; i_cnt_clr with hit same cycle -> o_hit_cnt=0.
REQ-039 i_rst_n low mid-response -> all outputs 0 immediately, o_req_ready=1 after release.

Source files
------------

// File: rtl/tag_match_pkg.sv
// Shared defaults for the tag-match pipeline and the index-width helper.
package tag_match_pkg;

  localparam int TAG_W_DEF = 20;
  localparam int WAYS_DEF  = 4;
  localparam int CNT_W_DEF = 16;

  // Index width never drops below one bit, even for two ways.
  function automatic int idx_w(input int ways);
    return (ways <= 2) ? 1 : $clog2(ways);
  endfunction

endpackage

// File: rtl/tag_eq.sv
// Full-width equality of two tags by XOR followed by NOR-reduce.
module tag_eq #(
  parameter int W = 20
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq
);

  assign eq = ~|(a ^ b);

endmodule

// File: rtl/tag_match_pipe.sv
// Parallel tag compare across WAYS with a one-deep registered response stage
// and saturating hit/miss statistics.
module tag_match_pipe
  import tag_match_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF,
  parameter int WAYS  = WAYS_DEF,
  parameter int CNT_W = CNT_W_DEF,
  localparam int IDX_W = idx_w(WAYS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [TAG_W-1:0]      i_tag,
  input  logic [WAYS*TAG_W-1:0] i_way_tag,
  input  logic [WAYS-1:0]       i_way_vld,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic                  o_hit,
  output logic [WAYS-1:0]       o_hit_oh,
  output logic [IDX_W-1:0]      o_hit_idx,
  output logic                  o_multi_hit,
  input  logic                  i_cnt_clr,
  output logic [CNT_W-1:0]      o_hit_cnt,
  output logic [CNT_W-1:0]      o_miss_cnt
);

  logic [WAYS-1:0]  tag_equal;
  logic [WAYS-1:0]  match;
  logic             match_any;
  logic             match_multi;
  logic [IDX_W-1:0] match_idx;
  logic             accept;

  for (genvar k = 0; k < WAYS; k++) begin : g_way
    tag_eq #(.W(TAG_W)) u_eq (
      .a  (i_way_tag[k*TAG_W +: TAG_W]),
      .b  (i_tag),
      .eq (tag_equal[k])
    );
  end

  assign match       = tag_equal & i_way_vld;
  assign match_any   = |match;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign match_multi = |(match & (match - WAYS'(1)));

  always_comb begin
    match_idx = '0;
    for (int k = WAYS - 1; k >= 0; k--) begin
      if (match[k]) match_idx = IDX_W'(k);
    end
  end

  assign o_req_ready = ~o_rsp_valid | i_rsp_ready;
  assign accept      = i_req_valid & o_req_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_valid <= 1'b0;
      o_hit       <= 1'b0;
      o_hit_oh    <= '0;
      o_hit_idx   <= '0;
      o_multi_hit <= 1'b0;
    end else if (accept) begin
      o_rsp_valid <= 1'b1;
      o_hit       <= match_any;
      o_hit_oh    <= match;
      o_hit_idx   <= match_idx;
      o_multi_hit <= match_multi;
    end else if (i_rsp_ready) begin
      o_rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else if (i_cnt_clr) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else if (accept) begin
      if (match_any) begin
        if (o_hit_cnt != '1) o_hit_cnt <= o_hit_cnt + CNT_W'(1);
      end else begin
        if (o_miss_cnt != '1) o_miss_cnt <= o_miss_cnt + CNT_W'(1);
      end
    end
  end

endmodule
